rf_mp: RTL

RF_MP -- requirements
Module: rf_mp

---
 rtl/rf_mp.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rf_mp.sv
// rf_mp: multi-read-port register file with byte-enable writes and a
// hardware clear sequencer.
//
// The storage array has no reset so it can map onto block RAM. The all-zero
// state is produced instead by a sequencer that walks every address once.
// It runs after reset and on each clr_req pulse.
//
// Ports
//   clka     : single clock, rising edge
//   rst      : asynchronous active-high reset; restarts the clear sequence
//   wr_en    : write request (ignored while busy or when clr_req is high)
//   wr_addr  : write address, AW bits
//   wr_be    : byte enables, bit k covers wr_data[8k+7:8k]
//   wr_data  : write data, WIDTH bits
//   rd_en    : per-port read request, NRD bits
//   rd_addr  : NRD packed addresses, port p at [p*AW +: AW]
//   rd_data  : NRD packed read words, port p at [p*WIDTH +: WIDTH]
//   rd_valid : rd_data of port p was updated on the last edge
//   clr_req  : one-cycle request to zero the whole array
//   busy     : clear sequence in progress
module rf_mp #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 512,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = WIDTH / 8
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [NB-1:0]        wr_be,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    input  logic                 clr_req,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_wr;

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;
    // clr_req wins over a coincident write; writes during a clear are dropped.
    assign w_wr   = wr_en & ~w_busy & ~clr_req;

    // Clear sequencer. Reset lands directly in CLEAR so the array is zeroed
    // after every reset; clr_req is not sampled while already clearing.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the sequencer and the user write.
    always_ff @(posedge clka) begin
        if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    r_mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Independent read ports, each with its own output register.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_old;
        logic [WIDTH-1:0] w_fwd;
        logic [WIDTH-1:0] r_data;
        logic             r_vld;

        assign w_addr = rd_addr[p*AW +: AW];
        assign w_old  = r_mem[w_addr];

        // Write-first forwarding: enabled bytes of a same-address write are
        // taken from wr_data, the rest from the stored word.
        always_comb begin
            w_fwd = w_old;
            if (BYPASS != 0 && w_wr && wr_addr == w_addr) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_be[k]) begin
                        w_fwd[8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clka or posedge rst) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= rd_en[p] & ~w_busy;
                if (rd_en[p] & ~w_busy) begin
                    r_data <= w_fwd;
                end
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = r_data;
        assign rd_valid[p]               = r_vld;
    end

endmodule
